// File: rtl/flag_stack_reg.sv
// ---------------------------------------------------------------------------
// flag_stack_reg
//
// Condition-flag register with per-bit update enables and a LIFO save/restore
// stack that preserves flag context across interrupts and calls. It sits
// between the ALU flag outputs and the branch-condition logic.
//
// Parameters
//   NFLAGS : number of flag bits (default ordering bit2=N, bit1=V, bit0=Z)
//   DEPTH  : save-stack entries (>= 1)
//   CW     : width of the occupancy count, derived from DEPTH
//
// Ports
//   clk       : system clock, all state updates on the rising edge
//   rst_n     : synchronous reset, active HIGH (1 = reset)
//   flags_in  : new flag values from the ALU
//   flag_wen  : per-bit update enable for flags_in
//   push      : save live flags onto the stack
//   pop       : restore live flags from the stack top
//   clr_err   : clear both sticky error flags
//   flags_out : live flag register
//   depth     : stack occupancy, 0..DEPTH
//   empty     : depth == 0
//   full      : depth == DEPTH
//   ovf_err   : sticky, push attempted while full
//   unf_err   : sticky, pop attempted while empty
// ---------------------------------------------------------------------------
module flag_stack_reg #(
    parameter int NFLAGS = 3,
    parameter int DEPTH  = 4,
    parameter int CW     = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NFLAGS-1:0] flags_in,
    input  logic [NFLAGS-1:0] flag_wen,
    input  logic              push,
    input  logic              pop,
    input  logic              clr_err,
    output logic [NFLAGS-1:0] flags_out,
    output logic [CW-1:0]     depth,
    output logic              empty,
    output logic              full,
    output logic              ovf_err,
    output logic              unf_err
);

    // Stack index width; at least one bit so DEPTH=1 still has a legal index.
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // One decoded operation per cycle; the priority order of the decode
    // below resolves every push/pop/empty/full combination.
    typedef enum logic [2:0] {
        OP_HOLD,    // plain per-bit update (or nothing)
        OP_PUSH,    // save live flags, depth++
        OP_POP,     // restore from top, depth--
        OP_XCHG,    // swap live flags with stack top, depth unchanged
        OP_OVF,     // push while full: error, update still applies
        OP_UNF      // pop while empty (with or without push): error, update applies
    } op_e;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [NFLAGS-1:0] flags_q;
    logic [CW-1:0]     depth_q;
    logic              ovf_q;
    logic              unf_q;
    logic [NFLAGS-1:0] stack_mem [0:DEPTH-1];

    // -----------------------------------------------------------------------
    // Decode
    // -----------------------------------------------------------------------
    op_e               op;
    logic              empty_q;
    logic              full_q;
    logic [AW-1:0]     wr_idx;
    logic [AW-1:0]     top_idx;
    logic [NFLAGS-1:0] top_val;
    logic [NFLAGS-1:0] upd_val;

    logic [NFLAGS-1:0] flags_nxt;
    logic [CW-1:0]     depth_nxt;
    logic              ovf_set;
    logic              unf_set;

    always_comb begin
        empty_q = (depth_q == '0);
        full_q  = (depth_q == CW'(DEPTH));
        wr_idx  = AW'(depth_q);
        // Wraps when empty; the value is unused in that case because an
        // empty pop decodes to OP_UNF.
        top_idx = AW'(depth_q - CW'(1));
    end

    always_comb begin
        top_val = stack_mem[top_idx];
        upd_val = (flags_q & ~flag_wen) | (flags_in & flag_wen);
    end

    always_comb begin
        op = OP_HOLD;
        if (pop && empty_q) begin
            op = OP_UNF;
        end else if (pop && push) begin
            op = OP_XCHG;
        end else if (pop) begin
            op = OP_POP;
        end else if (push && full_q) begin
            op = OP_OVF;
        end else if (push) begin
            op = OP_PUSH;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state
    // -----------------------------------------------------------------------
    always_comb begin
        flags_nxt = upd_val;
        depth_nxt = depth_q;
        ovf_set   = 1'b0;
        unf_set   = 1'b0;
        unique case (op)
            OP_HOLD: ;
            OP_PUSH: depth_nxt = depth_q + CW'(1);
            OP_POP: begin
                // Restore overrides any per-bit update in the same cycle.
                flags_nxt = top_val;
                depth_nxt = depth_q - CW'(1);
            end
            OP_XCHG: flags_nxt = top_val;
            OP_OVF:  ovf_set   = 1'b1;
            OP_UNF:  unf_set   = 1'b1;
            default: ;
        endcase
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst_n) begin
            flags_q <= '0;
            depth_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            flags_q <= flags_nxt;
            depth_q <= depth_nxt;
            // Set beats clear when both happen in the same cycle.
            ovf_q   <= ovf_set | (ovf_q & ~clr_err);
            unf_q   <= unf_set | (unf_q & ~clr_err);
        end
    end

    // Stack storage is not reset: a reset zeroes depth, so stale entries are
    // never read back before being overwritten by a push.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            if (op == OP_PUSH) begin
                stack_mem[wr_idx] <= flags_q;
            end else if (op == OP_XCHG) begin
                stack_mem[top_idx] <= flags_q;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs (all derived from registered state)
    // -----------------------------------------------------------------------
    always_comb begin
        flags_out = flags_q;
        depth     = depth_q;
        empty     = empty_q;
        full      = full_q;
        ovf_err   = ovf_q;
        unf_err   = unf_q;
    end

endmodule
